ahb_arb2: RTL

AHB_ARB2 -- requirements
Module: ahb_arb2

---
 rtl/ahb_pkg.sv | 33 +++
 rtl/ahb_rr_arb.sv | 35 +++
 rtl/ahb_arb2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-lite encodings and arbiter state type for the two-master bus arbiter.
package ahb_pkg;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HsizeByte   = 3'b000,
        HsizeHalf   = 3'b001,
        HsizeWord   = 3'b010,
        HsizeDword  = 3'b011,
        Hsize4Word  = 3'b100,
        Hsize8Word  = 3'b101,
        Hsize16Word = 3'b110,
        Hsize32Word = 3'b111
    } hsize_e;

    typedef enum logic [1:0] {
        StPark = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } arb_state_e;

    // BUSY and SEQ continue a burst, so the bus cannot change hands on them.
    function automatic logic htrans_in_burst(input logic [1:0] trans);
        return (trans == HtransBusy) || (trans == HtransSeq);
    endfunction

endpackage

// File: rtl/ahb_rr_arb.sv
// Two-requester round-robin picker; the last-grant pointer doubles as the bus hmaster.
module ahb_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       gnt_valid,
    output logic       gnt_idx,
    output logic       last_q
);

    logic last_d;

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = last_q;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last_q;
            default: gnt_idx = last_q;
        endcase
        // With no requester the pointer keeps the last owner.
        last_d = (advance && gnt_valid) ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ahb_arb2.sv
// Two-master AHB-lite arbiter with address/data phase pipelining.
// Define AHB_ARB_LOCK_EN to add hmastlock inputs that pin the current owner.
module ahb_arb2
    import ahb_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_busreq,
    input  logic          m1_busreq,
    input  logic [1:0]    m0_htrans,
    input  logic [1:0]    m1_htrans,
    input  logic [AW-1:0] m0_haddr,
    input  logic [AW-1:0] m1_haddr,
    input  logic          m0_hwrite,
    input  logic          m1_hwrite,
    input  logic [2:0]    m0_hsize,
    input  logic [2:0]    m1_hsize,
    input  logic [DW-1:0] m0_hwdata,
    input  logic [DW-1:0] m1_hwdata,
`ifdef AHB_ARB_LOCK_EN
    input  logic          m0_hmastlock,
    input  logic          m1_hmastlock,
    output logic          s_hmastlock,
`endif
    output logic          m0_hgrant,
    output logic          m1_hgrant,
    output logic          m0_hready,
    output logic          m1_hready,
    output logic          m0_hresp,
    output logic          m1_hresp,
    output logic [DW-1:0] hrdata,
    output logic [1:0]    s_htrans,
    output logic [AW-1:0] s_haddr,
    output logic          s_hwrite,
    output logic [2:0]    s_hsize,
    output logic [DW-1:0] s_hwdata,
    input  logic [DW-1:0] s_hrdata,
    input  logic          s_hready,
    input  logic          s_hresp,
    output logic          hmaster
);

    arb_state_e state_q, state_d;
    logic       hmaster_q;
    logic       dmaster_q, dmaster_d;
    logic       dvalid_q, dvalid_d;
    logic [1:0] own_htrans;
    logic       own_lock;
    logic       arb_point;
    logic       advance;
    logic       gnt_valid;
    logic       gnt_idx;

    always_comb begin
        own_htrans = HtransIdle;
        if (state_q != StPark) begin
            own_htrans = hmaster_q ? m1_htrans : m0_htrans;
        end
    end

`ifdef AHB_ARB_LOCK_EN
    assign own_lock = (state_q != StPark) && (hmaster_q ? m1_hmastlock : m0_hmastlock);
`else
    assign own_lock = 1'b0;
`endif

    assign arb_point = s_hready && !htrans_in_burst(own_htrans);
    assign advance   = arb_point && !own_lock;

    ahb_rr_arb u_rr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({m1_busreq, m0_busreq}),
        .advance   (advance),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .last_q    (hmaster_q)
    );

    always_comb begin
        state_d = state_q;
        if (advance) begin
            if (!gnt_valid) begin
                state_d = StPark;
            end else begin
                state_d = gnt_idx ? StOwn1 : StOwn0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StPark;
        end else begin
            state_q <= state_d;
        end
    end

    // Data-phase owner follows the address phase accepted on each ready cycle.
    always_comb begin
        dmaster_d = dmaster_q;
        dvalid_d  = dvalid_q;
        if (s_hready) begin
            dmaster_d = hmaster_q;
            dvalid_d  = (s_htrans != HtransIdle);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmaster_q <= 1'b0;
            dvalid_q  <= 1'b0;
        end else begin
            dmaster_q <= dmaster_d;
            dvalid_q  <= dvalid_d;
        end
    end

    assign m0_hgrant = (state_q == StOwn0);
    assign m1_hgrant = (state_q == StOwn1);
    assign hmaster   = hmaster_q;

    // Address bus is quiet while parked so nothing stray reaches the slave.
    always_comb begin
        s_htrans = HtransIdle;
        s_haddr  = '0;
        s_hwrite = 1'b0;
        s_hsize  = HsizeByte;
        if (state_q != StPark) begin
            s_htrans = hmaster_q ? m1_htrans : m0_htrans;
            s_haddr  = hmaster_q ? m1_haddr  : m0_haddr;
            s_hwrite = hmaster_q ? m1_hwrite : m0_hwrite;
            s_hsize  = hmaster_q ? m1_hsize  : m0_hsize;
        end
    end

`ifdef AHB_ARB_LOCK_EN
    assign s_hmastlock = own_lock;
`endif

    always_comb begin
        s_hwdata = '0;
        if (dvalid_q) begin
            s_hwdata = dmaster_q ? m1_hwdata : m0_hwdata;
        end
    end

    assign hrdata    = s_hrdata;
    assign m0_hresp  = s_hresp && dvalid_q && !dmaster_q;
    assign m1_hresp  = s_hresp && dvalid_q && dmaster_q;
    assign m0_hready = s_hready && (m0_hgrant || (dvalid_q && !dmaster_q));
    assign m1_hready = s_hready && (m1_hgrant || (dvalid_q && dmaster_q));

endmodule
